// File: rtl/pattern_pkg.sv
// Shared state type and window-count helpers
// for the streaming pattern counter.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pc_state_t;

  function automatic int win_in_byte(input int pat_w);
    return 9 - pat_w;
  endfunction

  function automatic int total_win(input int n, input int p);
    return 8 * n - p + 1;
  endfunction

endpackage

// File: rtl/byte_match_unit.sv
// Combinational per-byte match counter: in-byte windows
// and stream windows that end inside the current byte.
module byte_match_unit #(
  parameter int PAT_W = 4,
  localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1
) (
  input  logic [PAT_W-1:0]  pat,
  input  logic [TAIL_W-1:0] tail,
  input  logic [7:0]        byte_val,
  input  logic              first,
  output logic [3:0]        n_in,
  output logic [3:0]        n_str,
  output logic              hit
);
  import pattern_pkg::*;

  localparam int WIB = win_in_byte(PAT_W);

  always_comb begin
    n_in = '0;
    for (int k = 0; k < WIB; k++)
      if (byte_val[k +: PAT_W] == pat)
        n_in = n_in + 4'd1;
  end

  assign hit = |n_in;

  generate
    if (PAT_W == 1) begin : g_no_tail
      logic unused_tail;
      assign unused_tail = ^{tail, first};
      assign n_str = n_in;
    end else begin : g_tail
      logic [TAIL_W+7:0] ext;
      logic [3:0]        n_cross;

      assign ext = {tail, byte_val};

      // windows whose LSB lies in the current byte
      always_comb begin
        n_cross = '0;
        for (int k = 0; k < 8; k++)
          if (ext[k +: PAT_W] == pat)
            n_cross = n_cross + 4'd1;
      end

      assign n_str = first ? n_in : n_cross;
    end
  endgenerate

endmodule

// File: rtl/pattern_count_stream.sv
// Streaming pattern counter: FSM, byte index,
// tail register and the three match accumulators.
module pattern_count_stream #(
  parameter int PAT_W  = 4,
  parameter int NBYTES = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic [CNT_W-1:0] ctb,
  output logic [CNT_W-1:0] cts,
  output logic [CNT_W-1:0] cto,
  output logic             done
);
  import pattern_pkg::*;

  localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  pc_state_t         state;
  pc_state_t         state_nxt;
  logic [PAT_W-1:0]  pat_q;
  logic [IDX_W-1:0]  idx;
  logic [TAIL_W-1:0] tail_q;
  logic              accept;
  logic              last;
  logic              first;
  logic [3:0]        n_in;
  logic [3:0]        n_str;
  logic              hit;

  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign last     = (idx == LAST);
  assign first    = (idx == '0);
  assign done     = (state == DONE);

  byte_match_unit #(
    .PAT_W (PAT_W)
  ) u_match (
    .pat      (pat_q),
    .tail     (tail_q),
    .byte_val (in_byte),
    .first    (first),
    .n_in     (n_in),
    .n_str    (n_str),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!start && accept && last)
                 state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // start wins over a same-cycle accept
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      idx    <= '0;
      tail_q <= '0;
      ctb    <= '0;
      cts    <= '0;
      cto    <= '0;
    end else if (start) begin
      pat_q  <= pat;
      idx    <= '0;
      tail_q <= '0;
      ctb    <= '0;
      cts    <= '0;
      cto    <= '0;
    end else if (accept) begin
      idx    <= last ? '0 : idx + IDX_W'(1);
      tail_q <= in_byte[TAIL_W-1:0];
      ctb    <= ctb + CNT_W'(n_in);
      cts    <= cts + CNT_W'(n_str);
      cto    <= cto + CNT_W'(hit);
    end
  end

endmodule

// File: tb/tb_pattern_count_stream.sv
// Scoreboard bench for pattern_count_stream:
// builds (4,8), (3,4) and (1,4) against a bit-string model.
module tb_pattern_count_stream;

  typedef struct {
    int ctb;
    int cts;
    int cto;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_start, a_valid, a_ready, a_done;
  logic [3:0] a_pat;
  logic [7:0] a_byte;
  logic [7:0] a_ctb, a_cts, a_cto;

  logic       s_start, s_valid;
  logic [7:0] s_byte;
  logic [2:0] b_pat;
  logic       c_pat;
  logic       b_ready, b_done, c_ready, c_done;
  logic [5:0] b_ctb, b_cts, b_cto;
  logic [5:0] c_ctb, c_cts, c_cto;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] t_aa [8];
  logic [7:0] t_00 [8];
  logic [7:0] t_st [8];
  logic [7:0] t_ff [8];
  logic [7:0] t_rn [8];

  pattern_count_stream #(.PAT_W(4), .NBYTES(8), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .pat(a_pat),
    .in_valid(a_valid), .in_ready(a_ready), .in_byte(a_byte),
    .ctb(a_ctb), .cts(a_cts), .cto(a_cto), .done(a_done)
  );

  pattern_count_stream #(.PAT_W(3), .NBYTES(4), .CNT_W(6)) u_b (
    .clk(clk), .reset(reset), .start(s_start), .pat(b_pat),
    .in_valid(s_valid), .in_ready(b_ready), .in_byte(s_byte),
    .ctb(b_ctb), .cts(b_cts), .cto(b_cto), .done(b_done)
  );

  pattern_count_stream #(.PAT_W(1), .NBYTES(4), .CNT_W(6)) u_c (
    .clk(clk), .reset(reset), .start(s_start), .pat(c_pat),
    .in_valid(s_valid), .in_ready(c_ready), .in_byte(s_byte),
    .ctb(c_ctb), .cts(c_cts), .cto(c_cto), .done(c_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // whole string as one bit vector, b0 in the MSBs
  function automatic exp_t model(input int p, input int pw,
                                 input int n,
                                 input logic [7:0] bs [8]);
    exp_t        e;
    logic [63:0] s;
    int          m;
    int          h;
    e = '{0, 0, 0};
    m = (1 << pw) - 1;
    s = '0;
    for (int i = 0; i < n; i++) s = {s[55:0], bs[i]};
    for (int i = 0; i < n; i++) begin
      h = 0;
      for (int k = 0; k <= 8 - pw; k++)
        if (((bs[i] >> k) & m) == p) h++;
      e.ctb += h;
      if (h > 0) e.cto++;
    end
    for (int k = 0; k <= 8 * n - pw; k++)
      if (((s >> k) & m) == p) e.cts++;
    return e;
  endfunction

  task automatic run_a(input logic [3:0] p,
                       input logic [7:0] bs [8],
                       input bit gaps);
    exp_t e;
    int   acc = 0;
    int   cyc = 0;
    bit   early = 0;
    sb.push_back(model(int'(p), 4, 8, bs));
    @(negedge clk);
    a_start = 1'b1;
    a_pat   = p;
    a_valid = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    check("a_done_clr", a_done, 0);
    while (acc < 8 && cyc < 400) begin
      a_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_byte  = bs[acc];
      if (a_valid && a_ready) acc++;
      @(negedge clk);
      cyc++;
      if (acc < 8 && a_done) early = 1'b1;
    end
    a_valid = 1'b0;
    if (cyc >= 400) check("a_timeout", cyc, 0);
    check("a_done_early", early, 0);
    check("a_done_lat", a_done, 1);
    check("a_ready_done", a_ready, 0);
    a_valid = 1'b1;
    a_byte  = 8'hFF;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    e = sb.pop_front();
    check("a_ctb", a_ctb, e.ctb);
    check("a_cts", a_cts, e.cts);
    check("a_cto", a_cto, e.cto);
    check("a_done_hold", a_done, 1);
  endtask

  task automatic run_bc(input logic [2:0] pb, input logic pc,
                        input logic [7:0] bs [8]);
    exp_t e;
    int   acc = 0;
    int   cyc = 0;
    sb.push_back(model(int'(pb), 3, 4, bs));
    sb.push_back(model(int'(pc), 1, 4, bs));
    @(negedge clk);
    s_start = 1'b1;
    b_pat   = pb;
    c_pat   = pc;
    @(negedge clk);
    s_start = 1'b0;
    while (acc < 4 && cyc < 200) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_byte  = bs[acc];
      if (s_valid && b_ready && c_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    if (cyc >= 200) check("bc_timeout", cyc, 0);
    check("b_done", b_done, 1);
    check("c_done", c_done, 1);
    e = sb.pop_front();
    check("b_ctb", b_ctb, e.ctb);
    check("b_cts", b_cts, e.cts);
    check("b_cto", b_cto, e.cto);
    e = sb.pop_front();
    check("c_ctb", c_ctb, e.ctb);
    check("c_cts", c_cts, e.cts);
    check("c_cto", c_cto, e.cto);
  endtask

  initial begin
    reset   = 1'b1;
    a_start = 1'b0;
    a_valid = 1'b0;
    a_pat   = '0;
    a_byte  = '0;
    s_start = 1'b0;
    s_valid = 1'b0;
    s_byte  = '0;
    b_pat   = '0;
    c_pat   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t_aa[i] = 8'hAA;
      t_00[i] = 8'h00;
      t_st[i] = 8'h00;
    end
    t_st[0] = 8'h01;
    t_st[1] = 8'h80;
    t_ff = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (2) @(negedge clk);
    check("rst_ctb", a_ctb, 0);
    check("rst_cts", a_cts, 0);
    check("rst_cto", a_cto, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_ready, 0);
    reset = 1'b0;

    // inputs in IDLE are ignored
    a_valid = 1'b1;
    a_byte  = 8'hAA;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    check("idle_ready", a_ready, 0);
    check("idle_ctb", a_ctb, 0);

    run_a(4'b1010, t_aa, 1'b0);
    check("t1_ctb", a_ctb, 24);
    check("t1_cts", a_cts, 31);
    check("t1_cto", a_cto, 8);

    run_a(4'b0000, t_00, 1'b0);
    check("t2_ctb", a_ctb, 40);
    check("t2_cts", a_cts, 61);
    check("t2_cto", a_cto, 8);

    run_a(4'b0110, t_st, 1'b0);
    check("t3_ctb", a_ctb, 0);
    check("t3_cts", a_cts, 1);
    check("t3_cto", a_cto, 0);

    run_a(4'b1010, t_aa, 1'b1);
    check("t4_ctb", a_ctb, 24);
    check("t4_cts", a_cts, 31);
    check("t4_cto", a_cto, 8);

    // reset mid-run after 3 accepts
    @(negedge clk);
    a_start = 1'b1;
    a_pat   = 4'b1010;
    @(negedge clk);
    a_start = 1'b0;
    a_valid = 1'b1;
    a_byte  = 8'hAA;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    check("t5_part_ctb", a_ctb, 9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_ctb", a_ctb, 0);
    check("t5_cts", a_cts, 0);
    check("t5_cto", a_cto, 0);
    check("t5_done", a_done, 0);
    check("t5_ready", a_ready, 0);

    // partial run, then restart while in RUN
    @(negedge clk);
    a_start = 1'b1;
    a_pat   = 4'b1111;
    @(negedge clk);
    a_start = 1'b0;
    a_valid = 1'b1;
    a_byte  = 8'hFF;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    check("t5_run_ready", a_ready, 1);
    run_a(4'b1010, t_aa, 1'b0);
    check("t5r_ctb", a_ctb, 24);
    check("t5r_cts", a_cts, 31);
    check("t5r_cto", a_cto, 8);

    run_bc(3'b111, 1'b1, t_ff);
    check("t6_ctb", b_ctb, 18);
    check("t6_cts", b_cts, 20);
    check("t6_cto", b_cto, 3);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++)
        t_rn[i] = 8'($urandom_range(0, 255));
      run_a(4'($urandom_range(0, 15)), t_rn, 1'b1);
      run_bc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), t_rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
